contador_bcd_n: RTL and testbench

- Parametrised N-digit packed-BCD counter. It is the successor of the fixed 3-digit contador_BCD.
- Adds the following over its predecessor:
  - up, down, hold and saturating-up modes;
  - synchronous parallel load with per-digit validity check;
  - carry and borrow pulses;
  - a built-in time-multiplexed digit scanner for the 7-segment display path.
- Sits between the system timebase and the display driver. The carry output cascades into further counters.

---
 rtl/contador_bcd_n.sv | 137 +++++++++++++
 tb/tb_contador_bcd_n.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/contador_bcd_n.sv
// Parametrised N-digit packed-BCD up/down/saturating counter with parallel load
// and a built-in time-multiplexed digit scanner for the 7-segment display path.
module contador_bcd_n #(
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   input  logic [1:0]          sel,
   input  logic                load,
   input  logic [4*DIGITS-1:0] din,
   output logic [4*DIGITS-1:0] sal,
   output logic [3:0]          sal_aux,
   output logic [DIGITS-1:0]   an,
   output logic                carry,
   output logic                borrow,
   output logic                err
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_HOLD = 2'b10,
      MODE_SAT  = 2'b11
   } mode_t;

   mode_t               mode;
   logic [4*DIGITS-1:0] up_val;
   logic [4*DIGITS-1:0] down_val;
   logic [4*DIGITS-1:0] din_clean;
   logic                up_ripple;
   logic                down_ripple;
   logic                din_bad;
   logic [PW-1:0]       pre;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       idx_next;

   assign mode = mode_t'(sel);

   // A ripple still set past the top digit means every digit wrapped (all-9s up, all-0s down).
   always_comb begin
      up_val      = '0;
      down_val    = '0;
      din_clean   = '0;
      up_ripple   = 1'b1;
      down_ripple = 1'b1;
      din_bad     = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!up_ripple) begin
            up_val[4*i +: 4] = sal[4*i +: 4];
         end else if (sal[4*i +: 4] == 4'd9) begin
            up_val[4*i +: 4] = 4'd0;
         end else begin
            up_val[4*i +: 4] = sal[4*i +: 4] + 4'd1;
            up_ripple        = 1'b0;
         end

         if (!down_ripple) begin
            down_val[4*i +: 4] = sal[4*i +: 4];
         end else if (sal[4*i +: 4] == 4'd0) begin
            down_val[4*i +: 4] = 4'd9;
         end else begin
            down_val[4*i +: 4] = sal[4*i +: 4] - 4'd1;
            down_ripple        = 1'b0;
         end

         if (din[4*i +: 4] > 4'd9) begin
            din_bad = 1'b1;
         end else begin
            din_clean[4*i +: 4] = din[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sal    <= '0;
         carry  <= 1'b0;
         borrow <= 1'b0;
         err    <= 1'b0;
      end else begin
         carry  <= 1'b0;
         borrow <= 1'b0;
         err    <= 1'b0;
         if (load) begin
            sal <= din_clean;
            err <= din_bad;
         end else if (clk_en) begin
            case (mode)
               MODE_UP: begin
                  sal   <= up_val;
                  carry <= up_ripple;
               end
               MODE_DOWN: begin
                  sal    <= down_val;
                  borrow <= down_ripple;
               end
               MODE_SAT: begin
                  if (!up_ripple) sal <= up_val;
               end
               default: ;
            endcase
         end
      end
   end

   assign idx_next = (idx == IDX_LAST) ? '0 : idx + IW'(1);

   // Scanner free-runs from the system clock so the display refresh never stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre <= '0;
         idx <= '0;
         an  <= DIGITS'(1);
      end else if (pre == PRE_LAST) begin
         pre <= '0;
         idx <= idx_next;
         an  <= DIGITS'(1) << idx_next;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   always_comb begin
      sal_aux = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) sal_aux = sal[4*i +: 4];
      end
   end

endmodule

// File: tb/tb_contador_bcd_n.sv
// Self-checking bench for contador_bcd_n: decimal-integer reference model plus
// directed scenarios and a randomized run.
module tb_contador_bcd_n;

   localparam int DIGITS   = 3;
   localparam int SCAN_DIV = 4;
   localparam int MODULUS  = 1000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clk_en = 1'b0;
   logic [1:0]        sel = 2'b00;
   logic              load = 1'b0;
   logic [4*DIGITS-1:0] din = '0;
   logic [4*DIGITS-1:0] sal;
   logic [3:0]        sal_aux;
   logic [DIGITS-1:0] an;
   logic              carry;
   logic              borrow;
   logic              err;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: count held as a plain decimal integer
   int m_val = 0;
   bit m_carry = 0, m_borrow = 0, m_err = 0;
   int m_pre = 0, m_idx = 0;

   contador_bcd_n #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .sel(sel), .load(load), .din(din),
      .sal(sal), .sal_aux(sal_aux), .an(an), .carry(carry), .borrow(borrow), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int pow10(input int n);
      int r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r = '0;
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return r;
   endfunction

   function automatic logic [3:0] exp_aux();
      return 4'((m_val / pow10(m_idx)) % 10);
   endfunction

   function automatic logic [DIGITS-1:0] exp_an();
      return DIGITS'(1) << m_idx;
   endfunction

   // Advance one clock edge and update the model from the inputs seen at that edge
   task automatic step();
      int v;
      bit bad;
      @(posedge clk);
      if (!rst) begin
         m_val = 0; m_carry = 0; m_borrow = 0; m_err = 0; m_pre = 0; m_idx = 0;
      end else begin
         m_carry = 0; m_borrow = 0; m_err = 0;
         if (load) begin
            v = 0; bad = 0;
            for (int k = 0; k < DIGITS; k++) begin
               if (din[4*k +: 4] > 9) bad = 1;
               else v = v + int'(din[4*k +: 4]) * pow10(k);
            end
            m_val = v; m_err = bad;
         end else if (clk_en) begin
            case (sel)
               2'b00: begin m_carry = (m_val == MODULUS - 1); m_val = (m_val + 1) % MODULUS; end
               2'b01: begin m_borrow = (m_val == 0); m_val = (m_val + MODULUS - 1) % MODULUS; end
               2'b11: if (m_val < MODULUS - 1) m_val = m_val + 1;
               default: ;
            endcase
         end
         if (m_pre == SCAN_DIV - 1) begin
            m_pre = 0; m_idx = (m_idx + 1) % DIGITS;
         end else m_pre = m_pre + 1;
      end
      #1;
   endtask

   task automatic applyStimulus(input bit r, input bit ld, input bit en, input logic [1:0] s,
                                input logic [4*DIGITS-1:0] d);
      rst = r; load = ld; clk_en = en; sel = s; din = d;
   endtask

   task automatic test_reset();
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 12'h777);
      step(); step();
      tests_run++; if (sal !== 12'h000) begin tests_failed++; $display("[TB] FAIL reset_sal: got %h want 000", sal); end
      tests_run++; if ({carry, borrow, err} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_pulses: got %b want 000", {carry, borrow, err}); end
      tests_run++; if (an !== 3'b001) begin tests_failed++; $display("[TB] FAIL reset_an: got %b want 001", an); end
      tests_run++; if (sal_aux !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_aux: got %h want 0", sal_aux); end
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, '0);
      step();
      tests_run++; if (sal !== 12'h001) begin tests_failed++; $display("[TB] FAIL reset_release: got %h want 001", sal); end
   endtask

   task automatic test_up_wrap();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 12'h998); step();
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, '0); step();
      tests_run++; if (sal !== 12'h999 || carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL up_999: got %h c=%b want 999 c=0", sal, carry); end
      step();
      tests_run++; if (sal !== 12'h000 || carry !== 1'b1) begin tests_failed++; $display("[TB] FAIL up_wrap: got %h c=%b want 000 c=1", sal, carry); end
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++; if (sal !== 12'h000 || carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL up_disabled: got %h c=%b want 000 c=0", sal, carry); end
      end
   endtask

   task automatic test_down_wrap();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 12'h001); step();
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, '0); step();
      tests_run++; if (sal !== 12'h000 || borrow !== 1'b0) begin tests_failed++; $display("[TB] FAIL down_000: got %h b=%b want 000 b=0", sal, borrow); end
      step();
      tests_run++; if (sal !== 12'h999 || borrow !== 1'b1 || carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL down_wrap: got %h b=%b c=%b want 999 b=1 c=0", sal, borrow, carry); end
      step();
      tests_run++; if (sal !== 12'h998 || borrow !== 1'b0) begin tests_failed++; $display("[TB] FAIL down_after: got %h b=%b want 998 b=0", sal, borrow); end
   endtask

   task automatic test_invalid_load();
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 12'h9A5); step();
      tests_run++; if (sal !== 12'h905 || err !== 1'b1) begin tests_failed++; $display("[TB] FAIL bad_load: got %h e=%b want 905 e=1", sal, err); end
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, '0); step();
      tests_run++; if (sal !== 12'h905 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL bad_load_after: got %h e=%b want 905 e=0", sal, err); end
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 12'h999); step();
      tests_run++; if (sal !== 12'h999 || {carry, err} !== 2'b00) begin tests_failed++; $display("[TB] FAIL load_wins: got %h ce=%b want 999 ce=00", sal, {carry, err}); end
   endtask

   task automatic test_saturate_hold();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 12'h999); step();
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, '0);
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++; if (sal !== 12'h999 || carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL saturate: got %h c=%b want 999 c=0", sal, carry); end
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 12'h123); step();
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, '0);
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++; if (sal !== 12'h123 || {carry, borrow} !== 2'b00) begin tests_failed++; $display("[TB] FAIL hold: got %h cb=%b want 123 cb=00", sal, {carry, borrow}); end
      end
      sel = 2'b11; step();
      tests_run++; if (sal !== 12'h124) begin tests_failed++; $display("[TB] FAIL sat_count: got %h want 124", sal); end
   endtask

   task automatic test_scanner();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 12'h456); step();
      load = 1'b0;
      for (int k = 0; k < 4 * SCAN_DIV * DIGITS; k++) begin
         clk_en = (k >= 2 * SCAN_DIV * DIGITS) ? 1'(($urandom % 2)) : 1'b0;
         step();
         tests_run++; if (an !== exp_an()) begin tests_failed++; $display("[TB] FAIL scan_an: got %b want %b", an, exp_an()); end
         tests_run++; if (sal_aux !== exp_aux()) begin tests_failed++; $display("[TB] FAIL scan_aux: got %h want %h", sal_aux, exp_aux()); end
      end
      clk_en = 1'b0;
      repeat (5) step();
      rst = 1'b0; step(); rst = 1'b1;
      tests_run++; if (an !== 3'b001 || sal_aux !== 4'd0) begin tests_failed++; $display("[TB] FAIL scan_reset: got an=%b aux=%h want 001 0", an, sal_aux); end
      for (int k = 0; k < SCAN_DIV + 1; k++) begin
         step();
         tests_run++; if (an !== exp_an()) begin tests_failed++; $display("[TB] FAIL scan_restart: got %b want %b", an, exp_an()); end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         applyStimulus(($urandom % 40) != 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                       2'($urandom), 12'($urandom));
         if (($urandom % 10) == 0) begin
            din = to_bcd(($urandom % 2) ? MODULUS - 1 : 0);
         end
         step();
         tests_run++; if (sal !== to_bcd(m_val)) begin tests_failed++; $display("[TB] FAIL rand_sal: got %h want %h", sal, to_bcd(m_val)); end
         tests_run++; if ({carry, borrow, err} !== {m_carry, m_borrow, m_err}) begin tests_failed++; $display("[TB] FAIL rand_pulses: got %b want %b", {carry, borrow, err}, {m_carry, m_borrow, m_err}); end
         tests_run++; if (an !== exp_an() || sal_aux !== exp_aux()) begin tests_failed++; $display("[TB] FAIL rand_scan: got an=%b aux=%h want %b %h", an, sal_aux, exp_an(), exp_aux()); end
      end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_invalid_load();
      test_saturate_hold();
      test_scanner();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
